// File: rtl/rng_sop_arbiter.sv
// ---------------------------------------------------------------------------
// rng_sop_arbiter
//
// Purpose:
//   Takes one 128-bit sample from the RNG engine and hands it out as four
//   32-bit words to a set of requesters. Requesters are served round-robin.
//   Each word is cleared in the buffer as soon as it has been handed out,
//   so a delivered random word never stays inside the block.
//   A watchdog reports an engine that fails to produce a sample in time.
//
// Parameters:
//   NUM_REQ     number of requesters (2..8)
//   TIMEOUT     WAIT cycles without a capture before timeout_err (1..65535)
//
// Ports:
//   rng_clk     clock, every register uses the rising edge
//   rng_rst     synchronous active-high reset
//   ctrl_en     block enable; low flushes the buffer and returns to IDLE
//   sop_valid   engine has a sample ready
//   sop_data    engine sample; word k is sop_data[32k+31:32k]
//   rng_busy    engine busy; blocks capture
//   rd_sop      one-cycle pulse acknowledging a capture
//   req         per-requester word request (level)
//   grant_ack   one-hot, one-cycle pulse; rnd_word is valid alongside it
//   rnd_word    delivered word, zero when no ack is high
//   words_avail words still waiting in the buffer (0..4)
//   timeout_err one-cycle pulse when the watchdog expires
// ---------------------------------------------------------------------------
module rng_sop_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic               rng_clk,
    input  logic               rng_rst,
    input  logic               ctrl_en,
    input  logic               sop_valid,
    input  logic [127:0]       sop_data,
    input  logic               rng_busy,
    output logic               rd_sop,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant_ack,
    output logic [31:0]        rnd_word,
    output logic [2:0]         words_avail,
    output logic               timeout_err
);

    localparam int               PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_REQ    = PTR_W'(NUM_REQ - 1);
    localparam logic [15:0]      TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic [NUM_REQ-1:0] ACK_REQ0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t             state_q;
    logic [3:0][31:0]   wordBuf_q;
    logic [2:0]         wordIdx_q;
    logic [2:0]         avail_q;
    logic [PTR_W-1:0]   rrPtr_q;
    logic [15:0]        wdog_q;
    logic               rdSop_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [31:0]        word_q;
    logic               tmo_q;

    logic [NUM_REQ-1:0] eligible;
    logic               grantValid_d;
    logic [PTR_W-1:0]   winner_d;
    logic [PTR_W-1:0]   cand;
    logic [15:0]        wdogInc;
    logic               captureHit;

    // A requester that is being acked right now is masked out, so a request
    // that is still held during its ack cycle is not served a second time.
    assign eligible   = req & ~ack_q;
    assign captureHit = sop_valid & ~rng_busy;
    assign wdogInc    = wdog_q + 16'd1;

    // Round-robin search: start one past the last winner and walk upward,
    // wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        grantValid_d = 1'b0;
        winner_d     = rrPtr_q;
        cand         = rrPtr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_REQ) ? '0 : cand + 1'b1;
            if (!grantValid_d && eligible[cand]) begin
                grantValid_d = 1'b1;
                winner_d     = cand;
            end
        end
    end

    // Controller FSM with all outputs registered. Flush (reset or enable low)
    // has priority over everything, including a capture on the same edge.
    always_ff @(posedge rng_clk) begin
        if (rng_rst || !ctrl_en) begin
            state_q   <= IDLE;
            wordBuf_q <= '0;
            wordIdx_q <= '0;
            avail_q   <= '0;
            rrPtr_q   <= LAST_REQ;
            wdog_q    <= '0;
            rdSop_q   <= 1'b0;
            ack_q     <= '0;
            word_q    <= '0;
            tmo_q     <= 1'b0;
        end else begin
            rdSop_q <= 1'b0;
            ack_q   <= '0;
            word_q  <= '0;
            tmo_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (captureHit) begin
                        wordBuf_q <= sop_data;
                        avail_q   <= 3'd4;
                        wordIdx_q <= '0;
                        wdog_q    <= '0;
                        rdSop_q   <= 1'b1;
                        state_q   <= DRAIN;
                    end else if (wdogInc == TIMEOUT_CNT) begin
                        // Expiry: report once, restart the count, keep waiting.
                        wdog_q <= '0;
                        tmo_q  <= 1'b1;
                    end else begin
                        wdog_q <= wdogInc;
                    end
                end
                DRAIN: begin
                    if (grantValid_d && (avail_q != 3'd0)) begin
                        ack_q                     <= ACK_REQ0 << winner_d;
                        word_q                    <= wordBuf_q[wordIdx_q[1:0]];
                        wordBuf_q[wordIdx_q[1:0]] <= '0;
                        if (wordIdx_q != 3'd4) begin
                            wordIdx_q <= wordIdx_q + 3'd1;
                        end
                        avail_q <= avail_q - 3'd1;
                        rrPtr_q <= winner_d;
                        // Last word granted: go back to waiting while the
                        // word itself appears on the outputs next cycle.
                        if (avail_q == 3'd1) begin
                            state_q <= WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_sop      = rdSop_q;
    assign grant_ack   = ack_q;
    assign rnd_word    = word_q;
    assign words_avail = avail_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_rng_sop_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rng_sop_arbiter
//
// Bench for rng_sop_arbiter with three requesters and a short watchdog.
// A behavioural model (word queue plus last-served index) predicts every
// output after every clock edge; a vector table and a few directed
// sequences cover the documented scenarios, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_rng_sop_arbiter;

    localparam int NR  = 3;
    localparam int TMO = 8;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_DRAIN = 2;

    logic          rng_clk = 1'b0;
    logic          rng_rst = 1'b1;
    logic          ctrl_en = 1'b0;
    logic          sop_valid = 1'b0;
    logic [127:0]  sop_data = '0;
    logic          rng_busy = 1'b0;
    logic          rd_sop;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] grant_ack;
    logic [31:0]   rnd_word;
    logic [2:0]    words_avail;
    logic          timeout_err;

    int checks = 0;
    int passes = 0;

    // Model state: undelivered words in delivery order and the last winner.
    int            mPhase = M_IDLE;
    logic [31:0]   mWords[$];
    int            mLast = NR - 1;
    int            mTimer = 0;
    logic          eRdSop = 1'b0;
    logic [NR-1:0] eAck = '0;
    logic [31:0]   eWord = '0;
    logic [2:0]    eAvail = '0;
    logic          eTmo = 1'b0;

    typedef struct {
        logic          en;
        logic          sv;
        logic          busy;
        logic [NR-1:0] rq;
        logic          expRdSop;
        logic [NR-1:0] expAck;
        logic [31:0]   expWord;
        logic [2:0]    expAvail;
        logic          expTmo;
    } vec_t;

    vec_t vecs[10];

    always #5 rng_clk = ~rng_clk;

    rng_sop_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT(TMO)
    ) dut (
        .rng_clk    (rng_clk),
        .rng_rst    (rng_rst),
        .ctrl_en    (ctrl_en),
        .sop_valid  (sop_valid),
        .sop_data   (sop_data),
        .rng_busy   (rng_busy),
        .rd_sop     (rd_sop),
        .req        (req),
        .grant_ack  (grant_ack),
        .rnd_word   (rnd_word),
        .words_avail(words_avail),
        .timeout_err(timeout_err)
    );

    // Hard stop in case something never returns.
    initial begin
        #2_000_000;
        $display("[TB] FAIL sim_time_limit: got still running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs as they are now.
    task automatic modelStep();
        logic [NR-1:0] prevAck;
        logic [1:0]    c;
        logic [1:0]    w;
        logic [127:0]  tmp;
        bit            found;
        if (rng_rst || !ctrl_en) begin
            mPhase = M_IDLE;
            mWords.delete();
            mLast  = NR - 1;
            mTimer = 0;
            eRdSop = 1'b0;
            eAck   = '0;
            eWord  = '0;
            eTmo   = 1'b0;
        end else begin
            prevAck = eAck;
            eRdSop  = 1'b0;
            eAck    = '0;
            eWord   = '0;
            eTmo    = 1'b0;
            if (mPhase == M_IDLE) begin
                mPhase = M_WAIT;
            end else if (mPhase == M_WAIT) begin
                if (sop_valid && !rng_busy) begin
                    mWords.delete();
                    tmp = sop_data;
                    for (int k = 0; k < 4; k++) begin
                        mWords.push_back(tmp[31:0]);
                        tmp = tmp >> 32;
                    end
                    eRdSop = 1'b1;
                    mTimer = 0;
                    mPhase = M_DRAIN;
                end else begin
                    mTimer++;
                    if (mTimer == TMO) begin
                        eTmo   = 1'b1;
                        mTimer = 0;
                    end
                end
            end else begin
                found = 1'b0;
                w     = '0;
                for (int k = 1; k <= NR; k++) begin
                    c = 2'((mLast + k) % NR);
                    if (!found && req[c] && !prevAck[c]) begin
                        found = 1'b1;
                        w     = c;
                    end
                end
                if (found && mWords.size() > 0) begin
                    eAck[w] = 1'b1;
                    eWord   = mWords.pop_front();
                    mLast   = int'(w);
                    if (mWords.size() == 0) begin
                        mPhase = M_WAIT;
                    end
                end
            end
        end
        eAvail = 3'(mWords.size());
    endtask

    task automatic checkOutput();
        checkVal("model rd_sop", 128'(rd_sop), 128'(eRdSop));
        checkVal("model grant_ack", 128'(grant_ack), 128'(eAck));
        checkVal("model rnd_word", 128'(rnd_word), 128'(eWord));
        checkVal("model words_avail", 128'(words_avail), 128'(eAvail));
        checkVal("model timeout_err", 128'(timeout_err), 128'(eTmo));
    endtask

    task automatic tick();
        @(posedge rng_clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input vec_t v);
        ctrl_en   = v.en;
        sop_valid = v.sv;
        rng_busy  = v.busy;
        req       = v.rq;
    endtask

    initial begin
        logic [NR-1:0] ackSeen[$];
        logic [NR-1:0] rrExp[4];
        int            pulseAt[$];
        int            cnt;

        // Basic capture with requester 0 holding its request: one word every
        // other cycle because the acked requester is masked for one cycle.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0,        3'd0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 3'b000, 32'h0,        3'd4, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b001, 32'h11111111, 3'd3, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 32'h0,        3'd3, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b001, 32'h22222222, 3'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 32'h0,        3'd2, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b001, 32'h33333333, 3'd1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b000, 32'h0,        3'd1, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 3'b001, 32'h44444444, 3'd0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 32'h0,        3'd0, 1'b0};
        rrExp[0] = 3'b001;
        rrExp[1] = 3'b010;
        rrExp[2] = 3'b001;
        rrExp[3] = 3'b010;

        $display("[TB] start");

        // Reset values
        rng_rst = 1'b1;
        repeat (3) tick();
        checkVal("reset rd_sop", 128'(rd_sop), 128'(0));
        checkVal("reset grant_ack", 128'(grant_ack), 128'(0));
        checkVal("reset rnd_word", 128'(rnd_word), 128'(0));
        checkVal("reset words_avail", 128'(words_avail), 128'(0));
        checkVal("reset timeout_err", 128'(timeout_err), 128'(0));
        rng_rst = 1'b0;

        // Vector table
        sop_data = 128'h44444444_33333333_22222222_11111111;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkVal($sformatf("vec%0d rd_sop", i), 128'(rd_sop), 128'(vecs[i].expRdSop));
            checkVal($sformatf("vec%0d grant_ack", i), 128'(grant_ack), 128'(vecs[i].expAck));
            checkVal($sformatf("vec%0d rnd_word", i), 128'(rnd_word), 128'(vecs[i].expWord));
            checkVal($sformatf("vec%0d words_avail", i), 128'(words_avail), 128'(vecs[i].expAvail));
            checkVal($sformatf("vec%0d timeout_err", i), 128'(timeout_err), 128'(vecs[i].expTmo));
        end
        checkVal("basic buffer cleared", dut.wordBuf_q, 128'(0));

        // Round-robin from a fresh pointer: 0,1,0,1 then restart at 0
        ctrl_en = 1'b0;
        req = '0;
        sop_valid = 1'b0;
        tick();
        ctrl_en = 1'b1;
        tick();
        sop_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        sop_valid = 1'b1;
        req = 3'b011;
        tick();
        checkVal("rr rd_sop", 128'(rd_sop), 128'(1));
        sop_valid = 1'b0;
        ackSeen.delete();
        for (int n = 0; n < 12 && ackSeen.size() < 4; n++) begin
            tick();
            if (grant_ack != '0) ackSeen.push_back(grant_ack);
        end
        checkVal("rr ack count", 128'(ackSeen.size()), 128'(4));
        for (int i = 0; i < 4 && i < ackSeen.size(); i++) begin
            checkVal($sformatf("rr ack%0d", i), 128'(ackSeen[i]), 128'(rrExp[i]));
        end
        sop_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        sop_valid = 1'b1;
        tick();
        sop_valid = 1'b0;
        tick();
        checkVal("rr restart winner", 128'(grant_ack), 128'(3'b001));
        for (int n = 0; n < 10 && words_avail != 3'd0; n++) tick();
        checkVal("rr drained", 128'(words_avail), 128'(0));
        req = '0;

        // Busy gating
        sop_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        sop_valid = 1'b1;
        rng_busy = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            checkVal("busy no rd_sop", 128'(rd_sop), 128'(0));
        end
        rng_busy = 1'b0;
        tick();
        checkVal("busy release rd_sop", 128'(rd_sop), 128'(1));
        checkVal("busy release avail", 128'(words_avail), 128'(4));
        sop_valid = 1'b0;
        req = 3'b111;
        for (int n = 0; n < 10 && words_avail != 3'd0; n++) tick();
        checkVal("busy drained", 128'(words_avail), 128'(0));
        req = '0;

        // Watchdog: pulses on the 8th, 16th and 24th WAIT cycle
        pulseAt.delete();
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (timeout_err) pulseAt.push_back(n);
        end
        checkVal("wdog pulse count", 128'(pulseAt.size()), 128'(3));
        for (int i = 0; i < 3 && i < pulseAt.size(); i++) begin
            checkVal($sformatf("wdog pulse%0d cycle", i), 128'(pulseAt[i]), 128'(8 * (i + 1)));
        end
        sop_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        sop_valid = 1'b1;
        tick();
        sop_valid = 1'b0;
        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (timeout_err) cnt++;
        end
        checkVal("wdog quiet in drain", 128'(cnt), 128'(0));

        // Flush after two delivered words
        req = 3'b001;
        cnt = 0;
        for (int n = 0; n < 10 && cnt < 2; n++) begin
            tick();
            if (grant_ack != '0) cnt++;
        end
        checkVal("flush pre acks", 128'(cnt), 128'(2));
        ctrl_en = 1'b0;
        tick();
        checkVal("flush grant_ack", 128'(grant_ack), 128'(0));
        checkVal("flush words_avail", 128'(words_avail), 128'(0));
        checkVal("flush buffer", dut.wordBuf_q, 128'(0));
        tick();
        ctrl_en = 1'b1;
        cnt = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (grant_ack != '0) cnt++;
        end
        checkVal("flush no later acks", 128'(cnt), 128'(0));

        // Capture condition on the same edge as enable falling
        sop_valid = 1'b1;
        ctrl_en = 1'b0;
        tick();
        checkVal("flush vs capture rd_sop", 128'(rd_sop), 128'(0));
        checkVal("flush vs capture avail", 128'(words_avail), 128'(0));
        sop_valid = 1'b0;
        ctrl_en = 1'b1;
        tick();

        // Reset on the capture edge
        sop_valid = 1'b1;
        rng_rst = 1'b1;
        tick();
        checkVal("rst capture rd_sop", 128'(rd_sop), 128'(0));
        checkVal("rst capture grant_ack", 128'(grant_ack), 128'(0));
        checkVal("rst capture rnd_word", 128'(rnd_word), 128'(0));
        checkVal("rst capture words_avail", 128'(words_avail), 128'(0));
        checkVal("rst capture timeout_err", 128'(timeout_err), 128'(0));
        rng_rst = 1'b0;
        sop_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checkVal("rst no late rd_sop", 128'(rd_sop), 128'(0));
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rng_rst   = ($urandom_range(0, 199) == 0);
            ctrl_en   = ($urandom_range(0, 39) != 0);
            sop_valid = ($urandom_range(0, 2) == 0);
            rng_busy  = ($urandom_range(0, 2) == 0);
            sop_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            req       = 3'($urandom_range(0, 7));
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
